trigger_arm_ctrl: RTL and testbench
===================================

TRIGGER_ARM_CTRL -- requirements
Module: trigger_arm_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_CH, 4, trigger channel count (1..16); POST_W, 16, post-trigger counter width; HOLD_W, 16, holdoff counter width; CNT_W, 16, fire-counter width.
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Cmd  input  8  command byte: 'A'(65) arm continuous, 'S'(83) arm single-shot, 'a'(97) disarm, 'F'(70) force trigger; other values ignored.
REQ-005 CmdValid  input  1  Cmd qualifier; Cmd acted on only in cycles with CmdValid=1.
REQ-006 ChTrig  input  NUM_CH  per-channel comparator trigger requests.
REQ-007 ChMask  input  NUM_CH  channel enable; bit=0 blocks that channel.
REQ-008 PostCount  input  POST_W  post-trigger cycles after the fire cycle; sampled at fire.
REQ-009 HoldoffCycles  input  HOLD_W  re-arm holdoff length; sampled at end of POST.
REQ-010 TriggerArmed  output  1  high while state=ARMED.
REQ-011 TriggerFire  output  1  one-cycle pulse, first cycle of POST.
REQ-012 TriggerCh  output  $clog2(NUM_CH) (min 1)  channel that caused last fire; held until next fire.
REQ-013 Forced  output  1  last fire came from 'F'; held until next fire.
REQ-014 Capturing  output  1  high while state=POST.
REQ-015 Done  output  1  one-cycle pulse when single-shot capture completes.
REQ-016 FireCount  output  CNT_W  number of fires since last arm from IDLE; wraps at 2^CNT_W.

Function
REQ-017 FSM SHALL have states IDLE, ARMED, POST, HOLDOFF; all outputs registered.
REQ-018 IDLE: 'A' -> ARMED, mode=continuous; 'S' -> ARMED, mode=single; either clears FireCount, disarm-pending.
REQ-019 ARMED: hit = |(qualified ChTrig & ChMask) or 'F'; hit sampled at edge k -> state=POST, TriggerFire=1, FireCount+1, post counter=PostCount after edge k.
REQ-020 TriggerCh SHALL be lowest-index masked channel asserting; on 'F'-only hit TriggerCh=0, Forced=1; channel hit with 'F' same cycle gives channel index, Forced=0.
REQ-021 ARMED with 'a' SHALL -> IDLE; 'a' wins over a same-cycle hit (no fire).
REQ-022 POST: counter decrements each cycle; POST lasts PostCount+1 cycles including fire cycle; PostCount=0 gives exactly one POST cycle.
REQ-023 End of POST: single mode or disarm-pending -> IDLE (Done=1 only if single mode); else HoldoffCycles=0 -> ARMED; else HOLDOFF with counter=HoldoffCycles.
REQ-024 HOLDOFF: lasts HoldoffCycles cycles, triggers ignored, then -> ARMED; 'a' -> IDLE next edge.
REQ-025 'a' in POST SHALL set disarm-pending; capture window not truncated.
REQ-026 'A'/'S' outside IDLE and 'F' outside ARMED SHALL be ignored.
REQ-027 ChMask change takes effect the same cycle; PostCount/HoldoffCycles changes do not affect a running count.

Reset
REQ-028 Reset low SHALL immediately force IDLE, mode=continuous, counters=0, disarm-pending=0, edge history=0, all outputs 0, regardless of state (mid-capture included).
REQ-029 First Cmd acted on SHALL be in the first edge after Reset deasserts.

Configuration
REQ-030 Macro TRIGGER_EDGE_DETECT_EN defined: ChTrig qualified as per-channel rising edge (ChTrig & ~ChTrig_prev), history updated every cycle in all states; a level already high when arming SHALL NOT fire.
REQ-031 Macro undefined: ChTrig level-sensitive; held-high enabled channel fires in the first ARMED cycle and again on every re-arm.

Verification
REQ-032 Reset, 'S', ChTrig=4'b0100 one cycle, PostCount=3 -> TriggerFire pulse, TriggerCh=2, Capturing 4 cycles, Done pulse, IDLE, FireCount=1.
REQ-033 'A', HoldoffCycles=5, PostCount=0, ChTrig held 4'b0001 (level build) -> fires every 7 cycles (1 POST+5 HOLDOFF+1 ARMED); FireCount increments each.
REQ-034 ARMED, 'a' and ChTrig=4'b1000 same cycle -> no TriggerFire, IDLE next cycle, FireCount unchanged.
REQ-035 ARMED, 'F' with ChMask=0 -> TriggerFire, Forced=1, TriggerCh=0; 'a' during POST -> POST completes, then IDLE, no HOLDOFF, no Done.
REQ-036 Reset asserted mid-POST (counter=10) -> all outputs 0 immediately; with TRIGGER_EDGE_DETECT_EN, ChTrig high before 'A' -> no fire until low-then-high.

Source files
------------

// File: rtl/trigger_arm_ctrl.sv
// ============================================================================
// Module      : trigger_arm_ctrl
// Description : Oscilloscope-style trigger arming controller. Accepts ASCII
//               command bytes (arm continuous / arm single / disarm / force),
//               qualifies per-channel trigger requests through a channel mask,
//               then sequences a post-trigger capture window and an optional
//               re-arm holdoff.
//               Optional feature macro: TRIGGER_EDGE_DETECT_EN
//                 defined   -> channel triggers are rising-edge qualified
//                 undefined -> channel triggers are level sensitive
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trigger_arm_ctrl #(
  parameter int NUM_CH = 4,
  parameter int POST_W = 16,
  parameter int HOLD_W = 16,
  parameter int CNT_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cmd,
  input  logic              cmd_valid,
  input  logic [NUM_CH-1:0] ch_trig,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [POST_W-1:0] post_count,
  input  logic [HOLD_W-1:0] holdoff_cycles,
  output logic              trigger_armed,
  output logic              trigger_fire,
  output logic [CH_W-1:0]   trigger_ch,
  output logic              forced,
  output logic              capturing,
  output logic              done,
  output logic [CNT_W-1:0]  fire_count
);

  // Command byte encodings (ASCII)
  localparam logic [7:0] C_CMD_ARM_CONT   = 8'd65;  // 'A'
  localparam logic [7:0] C_CMD_ARM_SINGLE = 8'd83;  // 'S'
  localparam logic [7:0] C_CMD_DISARM     = 8'd97;  // 'a'
  localparam logic [7:0] C_CMD_FORCE      = 8'd70;  // 'F'

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_POST    = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                mode_single_q, mode_single_d;
  logic                disarm_pend_q, disarm_pend_d;
  logic [POST_W-1:0]   post_cnt_q, post_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]    fire_count_q, fire_count_d;
  logic [CH_W-1:0]     trig_ch_q, trig_ch_d;
  logic                forced_q, forced_d;
  logic                fire_q, fire_d;
  logic                done_q, done_d;
  logic                armed_q, armed_d;
  logic                capturing_q, capturing_d;

  logic                cmd_arm_cont;
  logic                cmd_arm_single;
  logic                cmd_disarm;
  logic                cmd_force;
  logic [NUM_CH-1:0]   ch_qual;
  logic [NUM_CH-1:0]   ch_hit;
  logic                any_ch_hit;
  logic [CH_W-1:0]     hit_idx;

  // Decode the command byte; nothing is acted on without cmd_valid
  always_comb begin
    cmd_arm_cont   = cmd_valid && (cmd == C_CMD_ARM_CONT);
    cmd_arm_single = cmd_valid && (cmd == C_CMD_ARM_SINGLE);
    cmd_disarm     = cmd_valid && (cmd == C_CMD_DISARM);
    cmd_force      = cmd_valid && (cmd == C_CMD_FORCE);
  end

`ifdef TRIGGER_EDGE_DETECT_EN
  logic [NUM_CH-1:0] ch_prev_q, ch_prev_d;

  // Rising-edge qualification; history tracks the input in every state so a
  // level already high when arming does not look like a new edge
  always_comb begin
    ch_prev_d = ch_trig;
    ch_qual   = ch_trig & ~ch_prev_q;
  end

  // Trigger history register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_prev_q <= '0;
    end else begin
      ch_prev_q <= ch_prev_d;
    end
  end
`else
  // Level-sensitive qualification: a held request fires on every arm
  always_comb begin
    ch_qual = ch_trig;
  end
`endif

  // Mask the qualified requests and pick the lowest-index active channel
  always_comb begin
    ch_hit     = ch_qual & ch_mask;
    any_ch_hit = |ch_hit;
    hit_idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_hit[i]) begin
        hit_idx = CH_W'(i);
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    mode_single_d = mode_single_q;
    disarm_pend_d = disarm_pend_q;
    post_cnt_d    = post_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    fire_count_d  = fire_count_q;
    trig_ch_d     = trig_ch_q;
    forced_d      = forced_q;
    fire_d        = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_arm_cont || cmd_arm_single) begin
          state_d       = S_ARMED;
          mode_single_d = cmd_arm_single;
          fire_count_d  = '0;
          disarm_pend_d = 1'b0;
        end
      end

      S_ARMED: begin
        // Disarm has priority over any same-cycle hit
        if (cmd_disarm) begin
          state_d = S_IDLE;
        end else if (any_ch_hit || cmd_force) begin
          state_d      = S_POST;
          fire_d       = 1'b1;
          fire_count_d = fire_count_q + CNT_W'(1);
          post_cnt_d   = post_count;
          // A real channel hit is reported even if force arrived with it
          trig_ch_d    = any_ch_hit ? hit_idx : '0;
          forced_d     = !any_ch_hit;
        end
      end

      S_POST: begin
        // Disarm during capture is deferred so the window completes
        if (cmd_disarm) begin
          disarm_pend_d = 1'b1;
        end
        if (post_cnt_q == '0) begin
          if (mode_single_q || disarm_pend_q || cmd_disarm) begin
            state_d = S_IDLE;
            done_d  = mode_single_q;
          end else if (holdoff_cycles == '0) begin
            state_d = S_ARMED;
          end else begin
            state_d    = S_HOLDOFF;
            hold_cnt_d = holdoff_cycles;
          end
        end else begin
          post_cnt_d = post_cnt_q - POST_W'(1);
        end
      end

      S_HOLDOFF: begin
        // Counter enters at holdoff_cycles (>=1) and leaves on reaching 1
        if (cmd_disarm) begin
          state_d = S_IDLE;
        end else if (hold_cnt_q <= HOLD_W'(1)) begin
          state_d    = S_ARMED;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    armed_d     = (state_d == S_ARMED);
    capturing_d = (state_d == S_POST);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mode_single_q <= 1'b0;
      disarm_pend_q <= 1'b0;
      post_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      fire_count_q  <= '0;
      trig_ch_q     <= '0;
      forced_q      <= 1'b0;
      fire_q        <= 1'b0;
      done_q        <= 1'b0;
      armed_q       <= 1'b0;
      capturing_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_single_q <= mode_single_d;
      disarm_pend_q <= disarm_pend_d;
      post_cnt_q    <= post_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      fire_count_q  <= fire_count_d;
      trig_ch_q     <= trig_ch_d;
      forced_q      <= forced_d;
      fire_q        <= fire_d;
      done_q        <= done_d;
      armed_q       <= armed_d;
      capturing_q   <= capturing_d;
    end
  end

  assign trigger_armed = armed_q;
  assign trigger_fire  = fire_q;
  assign trigger_ch    = trig_ch_q;
  assign forced        = forced_q;
  assign capturing     = capturing_q;
  assign done          = done_q;
  assign fire_count    = fire_count_q;

endmodule

`default_nettype wire

// File: tb/tb_trigger_arm_ctrl.sv
// ============================================================================
// Module      : tb_trigger_arm_ctrl
// Description : Self-checking bench for trigger_arm_ctrl. A behavioural model
//               tracks armed / capture-cycles-left / holdoff-cycles-left and
//               predicts every output after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trigger_arm_ctrl;

  localparam int NUM_CH = 4;
  localparam int POST_W = 16;
  localparam int HOLD_W = 16;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;

  logic              clk;
  logic              rst_n;
  logic [7:0]        cmd;
  logic              cmd_valid;
  logic [NUM_CH-1:0] ch_trig;
  logic [NUM_CH-1:0] ch_mask;
  logic [POST_W-1:0] post_count;
  logic [HOLD_W-1:0] holdoff_cycles;
  logic              trigger_armed;
  logic              trigger_fire;
  logic [CH_W-1:0]   trigger_ch;
  logic              forced;
  logic              capturing;
  logic              done;
  logic [CNT_W-1:0]  fire_count;

  int vectors;
  int miscompares;

  // Behavioural model state
  bit               m_armed;
  int               m_post_left;
  int               m_hold_left;
  bit               m_single;
  bit               m_pend;
  logic [CNT_W-1:0] m_fc;
  int               m_ch;
  bit               m_forced;
  bit               m_fire;
  bit               m_done;
  logic [NUM_CH-1:0] m_prev;

  trigger_arm_ctrl #(
    .NUM_CH(NUM_CH), .POST_W(POST_W), .HOLD_W(HOLD_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
    .ch_trig(ch_trig), .ch_mask(ch_mask), .post_count(post_count),
    .holdoff_cycles(holdoff_cycles), .trigger_armed(trigger_armed),
    .trigger_fire(trigger_fire), .trigger_ch(trigger_ch), .forced(forced),
    .capturing(capturing), .done(done), .fire_count(fire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_post_left = 0; m_hold_left = 0; m_single = 0; m_pend = 0;
    m_fc = '0; m_ch = 0; m_forced = 0; m_fire = 0; m_done = 0; m_prev = '0;
  endtask

  // One rising edge worth of behaviour, from the inputs present at the edge
  task automatic model_step();
    logic [NUM_CH-1:0] q;
    logic [NUM_CH-1:0] hv;
    logic [31:0] lowbit;
    bit c_a, c_f, c_arm_c, c_arm_s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    c_a     = cmd_valid && cmd == 8'd97;
    c_f     = cmd_valid && cmd == 8'd70;
    c_arm_c = cmd_valid && cmd == 8'd65;
    c_arm_s = cmd_valid && cmd == 8'd83;
`ifdef TRIGGER_EDGE_DETECT_EN
    q = ch_trig & ~m_prev;
`else
    q = ch_trig;
`endif
    m_prev = ch_trig;
    hv = q & ch_mask;
    m_fire = 0;
    m_done = 0;
    if (m_armed) begin
      if (c_a) begin
        m_armed = 0;
      end else if (hv != 0 || c_f) begin
        m_armed = 0;
        m_fire = 1;
        m_fc = m_fc + 1'b1;
        m_post_left = int'(post_count) + 1;
        if (hv != 0) begin
          lowbit = 32'(hv) & (~32'(hv) + 32'd1);
          m_ch = $clog2(lowbit);
          m_forced = 0;
        end else begin
          m_ch = 0;
          m_forced = 1;
        end
      end
    end else if (m_post_left > 0) begin
      if (c_a) m_pend = 1;
      m_post_left--;
      if (m_post_left == 0) begin
        if (m_single || m_pend) m_done = m_single;
        else if (holdoff_cycles == 0) m_armed = 1;
        else m_hold_left = int'(holdoff_cycles);
      end
    end else if (m_hold_left > 0) begin
      if (c_a) begin
        m_hold_left = 0;
      end else begin
        m_hold_left--;
        if (m_hold_left == 0) m_armed = 1;
      end
    end else if (c_arm_c || c_arm_s) begin
      m_armed = 1;
      m_single = c_arm_s;
      m_fc = '0;
      m_pend = 0;
    end
  endtask

  task automatic check_all();
    chk("armed",     32'(trigger_armed), 32'(m_armed));
    chk("fire",      32'(trigger_fire),  32'(m_fire));
    chk("trig_ch",   32'(trigger_ch),    32'(m_ch));
    chk("forced",    32'(forced),        32'(m_forced));
    chk("capturing", 32'(capturing),     32'(m_post_left > 0));
    chk("done",      32'(done),          32'(m_done));
    chk("fire_cnt",  32'(fire_count),    32'(m_fc));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] c);
    cmd = c; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; cmd = 8'd0;
  endtask

  initial begin
    int unsigned r;
    vectors = 0; miscompares = 0;
    model_reset();
    rst_n = 1'b0; cmd = 8'd0; cmd_valid = 1'b0; ch_trig = '0; ch_mask = 4'hF;
    post_count = '0; holdoff_cycles = '0;

    // Reset state
    steps(2);
    rst_n = 1'b1;

    // Single shot, channel 2 for one cycle, 4-cycle capture then Done
    post_count = 16'd3;
    send(8'd83);
    ch_trig = 4'b0100;
    step();
    ch_trig = 4'b0000;
    steps(7);

    // Continuous with holdoff 5, post 0, channel 0 held
    holdoff_cycles = 16'd5; post_count = 16'd0;
    send(8'd65);
    ch_trig = 4'b0001;
    steps(30);
    ch_trig = 4'b0000;
    steps(8);

    // Disarm coincident with a hit on channel 3: no fire
    ch_trig = 4'b1000; cmd = 8'd97; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; ch_trig = 4'b0000;
    steps(3);

    // Force with all channels masked, then disarm mid-capture
    ch_mask = 4'h0; post_count = 16'd4; holdoff_cycles = 16'd2;
    send(8'd65);
    send(8'd70);
    steps(1);
    send(8'd97);
    steps(6);
    ch_mask = 4'hF;

    // Channel hit together with force: channel wins, not forced
    post_count = 16'd1;
    send(8'd83);
    ch_trig = 4'b0110; cmd = 8'd70; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; ch_trig = 4'b0000;
    steps(4);

    // Reset asserted mid-capture clears all outputs immediately
    post_count = 16'd20;
    send(8'd83);
    send(8'd70);
    steps(10);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_armed",   32'(trigger_armed), 32'd0);
    chk("rst_fire",    32'(trigger_fire),  32'd0);
    chk("rst_capture", 32'(capturing),     32'd0);
    chk("rst_fc",      32'(fire_count),    32'd0);
    chk("rst_forced",  32'(forced),        32'd0);
    model_reset();
    step();
    rst_n = 1'b1;

    // Trigger level high before arming; then low-then-high
    post_count = 16'd2; holdoff_cycles = 16'd0;
    ch_trig = 4'b0001;
    steps(2);
    send(8'd65);
    steps(3);
    ch_trig = 4'b0000;
    step();
    ch_trig = 4'b0001;
    steps(4);
    ch_trig = 4'b0000;
    send(8'd97);
    steps(2);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      cmd_valid = 1'b1;
      case (r)
        0: cmd = 8'd65;
        1: cmd = 8'd83;
        2: cmd = 8'd97;
        3, 4: cmd = 8'd70;
        5: cmd = 8'($urandom);
        default: begin cmd = 8'($urandom_range(60, 100)); cmd_valid = 1'b0; end
      endcase
      ch_trig = 4'($urandom) & 4'($urandom) & 4'($urandom);
      ch_mask = 4'($urandom) | 4'($urandom);
      post_count = 16'($urandom_range(0, 4));
      holdoff_cycles = 16'($urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
